// File: rtl/tdc_enc_pkg.sv
// Shared constants and state encoding for the TDC hit-mask encoder path.
// Width of the hit mask and of the channel index are fixed by find_one.
package tdc_enc_pkg;

    localparam int TDC_NCH   = 11;
    localparam int TDC_IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } tdc_state_e;

    // An out-of-range index (e.g. 4'hF) shifts the bit out and yields all zeros.
    function automatic logic [TDC_NCH-1:0] idx_to_onehot(input logic [TDC_IDX_W-1:0] idx);
        logic [TDC_NCH-1:0] one;
        one = {{(TDC_NCH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/find_one.sv
// Priority encoder: index of the lowest set bit of an 11-bit mask, 4'hF if empty.
module find_one
    import tdc_enc_pkg::*;
(
    input  logic [TDC_NCH-1:0]   din_i,
    output logic [TDC_IDX_W-1:0] idx_o
);

    // Scanning high-to-low lets the lowest set bit win the last assignment.
    always_comb begin
        idx_o = {TDC_IDX_W{1'b1}};
        for (int i = TDC_NCH - 1; i >= 0; i--) begin
            if (din_i[i]) idx_o = TDC_IDX_W'(i);
        end
    end

endmodule

// File: rtl/tdc_hit_scheduler.sv
// Serialises an accepted hit mask into one channel-index beat per hit, lowest
// channel first, each beat carrying the frame tag; counts emitted beats.
module tdc_hit_scheduler
    import tdc_enc_pkg::*;
#(
    parameter int DIN_WIDTH = TDC_NCH,
    parameter int IDX_WIDTH = TDC_IDX_W,
    parameter int TAG_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIN_WIDTH-1:0] in_mask,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_WIDTH-1:0] out_index,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_last,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] hit_total
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; while valid is high and ready low, the presenting side holds its data.

    tdc_state_e           state_q;
    logic                 run_q;
    logic [DIN_WIDTH-1:0] mask_q, mask_d;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [CNT_WIDTH-1:0] hit_total_q, hit_total_d;
    logic [IDX_WIDTH-1:0] idx;
    logic                 scan;
    logic                 rest_empty;

    find_one u_find_one (
        .din_i (mask_q),
        .idx_o (idx)
    );

    assign scan       = (state_q == SCAN);
    assign mask_d     = mask_q & ~idx_to_onehot(idx);
    assign rest_empty = (mask_d == '0);
    assign hit_total_d = (hit_total_q == '1) ? hit_total_q : hit_total_q + CNT_WIDTH'(1);

    // run_q keeps in_ready low while reset is asserted and for the first edge after it.
    assign in_ready  = run_q & enable & ~scan;
    assign out_valid = scan;
    assign busy      = scan;
    assign out_index = idx;
    assign out_tag   = tag_q;
    assign out_last  = scan & rest_empty;
    assign hit_total = hit_total_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            mask_q      <= '0;
            tag_q       <= '0;
            hit_total_q <= '0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    // An empty mask is consumed by the handshake but never scanned.
                    if (in_valid && in_ready && (in_mask != '0)) begin
                        mask_q  <= in_mask;
                        tag_q   <= in_tag;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        mask_q      <= mask_d;
                        hit_total_q <= hit_total_d;
                        if (rest_empty) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_hit_scheduler.sv
// Directed bench for tdc_hit_scheduler: every expected value is hand-derived.
module tb_tdc_hit_scheduler;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_mask;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic [7:0]  out_tag;
    logic        out_last;
    logic        busy;
    logic [15:0] hit_total;

    int          n_cmp;
    int          n_err;
    logic [15:0] exp_total;

    tdc_hit_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_tag   (out_tag),
        .out_last  (out_last),
        .busy      (busy),
        .hit_total (hit_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a frame from a negedge until in_ready is seen, let the next posedge
    // take it, then drop in_valid on the following negedge.
    task automatic drive_frame(input logic [10:0] mask, input logic [7:0] tag);
        bit got;
        got = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_mask  = mask;
        in_tag   = tag;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b required 1 for mask %h", in_ready, mask);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    // Wait (bounded) for the last beat to be shown, let it be taken, stop at the next negedge.
    task automatic drain_frame();
        bit done;
        done = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1 && out_last === 1'b1 && out_ready === 1'b1) begin
                done = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: out_valid=%b out_last=%b required 1/1", out_valid, out_last);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        exp_total = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        n_cmp += 5;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        if (hit_total !== 16'h0000) begin n_err++; $display("FAIL reset_hit_total: got %h want 0000", hit_total); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_two_hits();
        drive_frame(11'b000_0010_0100, 8'h3C);
        n_cmp += 5;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL two_v0: got %b want 1", out_valid); end
        if (out_index !== 4'd2) begin n_err++; $display("FAIL two_idx0: got %0d want 2", out_index); end
        if (out_last !== 1'b0) begin n_err++; $display("FAIL two_last0: got %b want 0", out_last); end
        if (out_tag !== 8'h3C) begin n_err++; $display("FAIL two_tag0: got %h want 3c", out_tag); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL two_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        #1;
        n_cmp += 3;
        if (out_index !== 4'd5) begin n_err++; $display("FAIL two_idx1: got %0d want 5", out_index); end
        if (out_last !== 1'b1) begin n_err++; $display("FAIL two_last1: got %b want 1", out_last); end
        if (out_tag !== 8'h3C) begin n_err++; $display("FAIL two_tag1: got %h want 3c", out_tag); end
        @(negedge clk);
        #1;
        exp_total = 16'd2;
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL two_done_valid: got %b want 0", out_valid); end
        if (hit_total !== exp_total) begin n_err++; $display("FAIL two_total: got %h want %h", hit_total, exp_total); end
    endtask

    task automatic test_all_hits();
        drive_frame(11'h7FF, 8'hA5);
        for (int i = 0; i <= 10; i++) begin
            n_cmp += 4;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL all_valid[%0d]: got %b want 1", i, out_valid); end
            if (out_index !== 4'(i)) begin n_err++; $display("FAIL all_idx[%0d]: got %0d want %0d", i, out_index, i); end
            if (out_last !== (i == 10)) begin n_err++; $display("FAIL all_last[%0d]: got %b want %b", i, out_last, (i == 10)); end
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL all_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(negedge clk);
            #1;
        end
        exp_total += 16'd11;
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL all_done_valid: got %b want 0", out_valid); end
        if (hit_total !== exp_total) begin n_err++; $display("FAIL all_total: got %h want %h", hit_total, exp_total); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_frame(11'h400, 8'h11);
        for (int i = 0; i < 5; i++) begin
            n_cmp += 5;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            if (out_index !== 4'd10) begin n_err++; $display("FAIL bp_idx[%0d]: got %0d want 10", i, out_index); end
            if (out_last !== 1'b1) begin n_err++; $display("FAIL bp_last[%0d]: got %b want 1", i, out_last); end
            if (out_tag !== 8'h11) begin n_err++; $display("FAIL bp_tag[%0d]: got %h want 11", i, out_tag); end
            if (hit_total !== exp_total) begin n_err++; $display("FAIL bp_total[%0d]: got %h want %h", i, hit_total, exp_total); end
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        exp_total += 16'd1;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_done_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL bp_done_busy: got %b want 0", busy); end
        if (hit_total !== exp_total) begin n_err++; $display("FAIL bp_total: got %h want %h", hit_total, exp_total); end
    endtask

    task automatic test_empty_mask();
        drive_frame(11'h000, 8'h77);
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL empty_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        #1;
        n_cmp += 2;
        if (busy !== 1'b0) begin n_err++; $display("FAIL empty_busy: got %b want 0", busy); end
        if (hit_total !== exp_total) begin n_err++; $display("FAIL empty_total: got %h want %h", hit_total, exp_total); end
    endtask

    task automatic test_async_reset();
        drive_frame(11'h7FF, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_index !== 4'd2) begin n_err++; $display("FAIL rst_third_idx: got %0d want 2", out_index); end
        rst_n = 1'b0;
        #1;
        exp_total = 16'h0000;
        n_cmp += 4;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_mid_last: got %b want 0", out_last); end
        if (hit_total !== exp_total) begin n_err++; $display("FAIL rst_mid_total: got %h want %h", hit_total, exp_total); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_frame(11'h001, 8'hC3);
        n_cmp += 4;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_new_valid: got %b want 1", out_valid); end
        if (out_index !== 4'd0) begin n_err++; $display("FAIL rst_new_idx: got %0d want 0", out_index); end
        if (out_last !== 1'b1) begin n_err++; $display("FAIL rst_new_last: got %b want 1", out_last); end
        if (out_tag !== 8'hC3) begin n_err++; $display("FAIL rst_new_tag: got %h want c3", out_tag); end
        @(negedge clk);
        #1;
        exp_total = 16'd1;
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_new_done: got %b want 0", out_valid); end
        if (hit_total !== exp_total) begin n_err++; $display("FAIL rst_new_total: got %h want %h", hit_total, exp_total); end
    endtask

    task automatic test_enable_saturate();
        @(negedge clk);
        enable   = 1'b0;
        in_valid = 1'b1;
        in_mask  = 11'h003;
        in_tag   = 8'h42;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp += 2;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL en_in_ready[%0d]: got %b want 0", i, in_ready); end
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL en_out_valid[%0d]: got %b want 0", i, out_valid); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        // Walk hit_total up to 16'hFFFE with full frames, then a partial one.
        while (exp_total <= 16'hFFFE - 16'd11) begin
            drive_frame(11'h7FF, 8'h00);
            drain_frame();
            exp_total += 16'd11;
        end
        if (exp_total != 16'hFFFE) begin
            drive_frame(11'((1 << (16'hFFFE - exp_total)) - 1), 8'h00);
            drain_frame();
            exp_total = 16'hFFFE;
        end
        n_cmp++;
        if (hit_total !== 16'hFFFE) begin n_err++; $display("FAIL sat_preload: got %h want fffe", hit_total); end
        drive_frame(11'h003, 8'h42);
        n_cmp += 2;
        if (out_index !== 4'd0) begin n_err++; $display("FAIL sat_idx0: got %0d want 0", out_index); end
        if (out_tag !== 8'h42) begin n_err++; $display("FAIL sat_tag: got %h want 42", out_tag); end
        drain_frame();
        n_cmp++;
        if (hit_total !== 16'hFFFF) begin n_err++; $display("FAIL sat_total: got %h want ffff", hit_total); end
        drive_frame(11'h001, 8'h43);
        drain_frame();
        n_cmp++;
        if (hit_total !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", hit_total); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_two_hits();
        test_all_hits();
        test_backpressure();
        test_empty_mask();
        test_async_reset();
        test_enable_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
